// File: rtl/cu_data_write_engine_arbiter_pkg.sv
// Shared types and constants for the CU write-path arbiter and its requesters.
package cu_data_write_engine_arbiter_pkg;

    localparam int CU_ID_BITS = 8;
    typedef logic [CU_ID_BITS-1:0] cu_id_t;

    localparam cu_id_t DATA_WRITE_CONTROL_ID = 8'h20;

    localparam int WRITE_ARB_NUM_REQ         = 4;
    localparam int WRITE_ARB_MAX_OUTSTANDING = 16;

    localparam cu_id_t WRITE_ENGINE_0_ID = DATA_WRITE_CONTROL_ID + 8'd0;
    localparam cu_id_t WRITE_ENGINE_1_ID = DATA_WRITE_CONTROL_ID + 8'd1;
    localparam cu_id_t WRITE_ENGINE_2_ID = DATA_WRITE_CONTROL_ID + 8'd2;
    localparam cu_id_t WRITE_ENGINE_3_ID = DATA_WRITE_CONTROL_ID + 8'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } arbiter_state_t;

    typedef struct packed {
        cu_id_t      cu_id;
        logic [3:0]  cmd_type;
        logic [7:0]  tag;
    } cmd_meta_t;

    typedef struct packed {
        logic        valid;
        cmd_meta_t   cmd;
        logic [31:0] address;
        logic [7:0]  size;
    } command_buffer_line_t;

    typedef struct packed {
        logic        valid;
        cmd_meta_t   cmd;
        logic [63:0] data;
    } read_write_data_line_t;

    typedef struct packed {
        logic        valid;
        cmd_meta_t   cmd;
    } response_buffer_line_t;

    typedef struct packed {
        logic alfull;
        logic full;
        logic empty;
    } buffer_status_t;

endpackage

// File: rtl/cu_data_write_engine_arbiter_rr.sv
// Round-robin priority pick: first set request at or after pointer, wrapping.
// Latency: purely combinational.
// Backpressure: enable low forces an all-zero grant.
module round_robin_priority_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int IDX_BITS = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [IDX_BITS-1:0] pointer,
    input  logic                enable,
    output logic [NUM_REQ-1:0]  grant,
    output logic [IDX_BITS-1:0] index
);

    logic                found;
    logic [IDX_BITS:0]   sum;
    logic [IDX_BITS-1:0] cand;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // extra bit keeps pointer+k from wrapping before the modulo step
            sum = {1'b0, pointer} + (IDX_BITS+1)'(k);
            if (sum >= (IDX_BITS+1)'(NUM_REQ)) begin
                sum = sum - (IDX_BITS+1)'(NUM_REQ);
            end
            cand = sum[IDX_BITS-1:0];
            if (enable && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                index       = cand;
            end
        end
    end

endmodule

// File: rtl/cu_data_write_engine_arbiter.sv
// Shares the CU write command/data path between NUM_REQ engines; routes responses back by cu_id.
// Latency: grant is combinational, winning line registered one cycle later; responses routed one cycle later.
// Backpressure: no grant while alfull, outstanding at limit, or not ACTIVE.
module cu_data_write_engine_arbiter
    import cu_data_write_engine_arbiter_pkg::*;
#(
    parameter int     NUM_REQ         = WRITE_ARB_NUM_REQ,
    parameter int     REQ_ID_BITS     = $clog2(NUM_REQ),
    parameter cu_id_t CU_ID_BASE      = DATA_WRITE_CONTROL_ID,
    parameter int     MAX_OUTSTANDING = WRITE_ARB_MAX_OUTSTANDING,
    parameter int     CNT_BITS        = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                                clock,
    input  logic                                rstn,
    input  logic                                enabled_in,
    input  logic [NUM_REQ-1:0]                  req_valid_in,
    input  command_buffer_line_t  [NUM_REQ-1:0] req_command_in,
    input  read_write_data_line_t [NUM_REQ-1:0] req_data_0_in,
    input  read_write_data_line_t [NUM_REQ-1:0] req_data_1_in,
    output logic [NUM_REQ-1:0]                  req_grant_out,
    input  buffer_status_t                      write_command_buffer_status,
    input  response_buffer_line_t               write_response_in,
    output command_buffer_line_t                write_command_out,
    output read_write_data_line_t               write_data_0_out,
    output read_write_data_line_t               write_data_1_out,
    output response_buffer_line_t [NUM_REQ-1:0] req_response_out,
    output logic [CNT_BITS-1:0]                 outstanding_out,
    output logic                                idle_out,
    output logic                                error_out
);

    arbiter_state_t         state;
    arbiter_state_t         state_next;
    logic                   enabled;
    logic [REQ_ID_BITS-1:0] rr_ptr;
    logic [REQ_ID_BITS-1:0] arb_idx;
    logic [NUM_REQ-1:0]     arb_grant;
    logic                   arb_enable;
    logic                   grant_vld;
    logic [CNT_BITS-1:0]    outstanding;
    cu_id_t                 winner_id;
    cu_id_t                 resp_off;
    logic                   resp_routable;
    logic                   resp_bad;
    logic                   underflow;
    logic                   unused_inputs;

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            enabled <= 1'b0;
            state   <= IDLE;
        end else begin
            enabled <= enabled_in;
            state   <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enabled) state_next = ACTIVE;
            end
            ACTIVE: begin
                if (!enabled) state_next = DRAIN;
            end
            DRAIN: begin
                if (enabled)                  state_next = ACTIVE;
                else if (outstanding == '0)   state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign arb_enable = (state == ACTIVE)
                     && !write_command_buffer_status.alfull
                     && (outstanding < CNT_BITS'(MAX_OUTSTANDING));

    round_robin_priority_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .IDX_BITS (REQ_ID_BITS)
    ) u_rr_arb (
        .req     (req_valid_in),
        .pointer (rr_ptr),
        .enable  (arb_enable),
        .grant   (arb_grant),
        .index   (arb_idx)
    );

    assign grant_vld     = |arb_grant;
    assign req_grant_out = arb_grant;
    assign winner_id     = CU_ID_BASE + cu_id_t'(arb_idx);

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            rr_ptr <= '0;
        end else if (grant_vld) begin
            rr_ptr <= (arb_idx == REQ_ID_BITS'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
        end
    end

    // Lines are zeroed on idle cycles so downstream can trust every field, not just valid.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            write_command_out <= '0;
            write_data_0_out  <= '0;
            write_data_1_out  <= '0;
        end else begin
            write_command_out <= '0;
            write_data_0_out  <= '0;
            write_data_1_out  <= '0;
            if (grant_vld) begin
                write_command_out           <= req_command_in[arb_idx];
                write_command_out.valid     <= 1'b1;
                write_command_out.cmd.cu_id <= winner_id;
                write_data_0_out            <= req_data_0_in[arb_idx];
                write_data_0_out.valid      <= 1'b1;
                write_data_0_out.cmd.cu_id  <= winner_id;
                write_data_1_out            <= req_data_1_in[arb_idx];
                write_data_1_out.valid      <= 1'b1;
                write_data_1_out.cmd.cu_id  <= winner_id;
            end
        end
    end

    // Full-width difference: ids below the base wrap high, so one compare rejects both sides.
    assign resp_off      = write_response_in.cmd.cu_id - CU_ID_BASE;
    assign resp_routable = write_response_in.valid && (resp_off < cu_id_t'(NUM_REQ));
    assign resp_bad      = write_response_in.valid && !(resp_off < cu_id_t'(NUM_REQ));
    assign underflow     = resp_routable && !grant_vld && (outstanding == '0);

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            req_response_out <= '0;
        end else begin
            req_response_out <= '0;
            if (resp_routable) begin
                req_response_out[resp_off[REQ_ID_BITS-1:0]] <= write_response_in;
            end
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            outstanding <= '0;
            error_out   <= 1'b0;
        end else begin
            case ({grant_vld, resp_routable})
                2'b10: outstanding <= outstanding + 1'b1;
                2'b01: begin
                    if (outstanding != '0) outstanding <= outstanding - 1'b1;
                end
                default: outstanding <= outstanding;
            endcase
            if (resp_bad || underflow) error_out <= 1'b1;
        end
    end

    assign outstanding_out = outstanding;
    assign idle_out        = (state == IDLE) && (outstanding == '0);

    // Valid bits and cu_ids of requester lines are replaced, buffer full/empty are informational.
    assign unused_inputs = ^{write_command_buffer_status, req_command_in, req_data_0_in, req_data_1_in};

endmodule

// File: tb/tb_cu_data_write_engine_arbiter.sv
// Table-driven plus scoreboard bench for the CU write-path arbiter.
module tb_cu_data_write_engine_arbiter;
    import cu_data_write_engine_arbiter_pkg::*;

    localparam int     N    = 4;
    localparam cu_id_t BASE = DATA_WRITE_CONTROL_ID;

    logic                            clock = 1'b0;
    logic                            rstn;
    logic                            enabled_in;
    logic [N-1:0]                    req_valid_in;
    command_buffer_line_t  [N-1:0]   req_command_in;
    read_write_data_line_t [N-1:0]   req_data_0_in;
    read_write_data_line_t [N-1:0]   req_data_1_in;
    logic [N-1:0]                    req_grant_out;
    buffer_status_t                  write_command_buffer_status;
    response_buffer_line_t           write_response_in;
    command_buffer_line_t            write_command_out;
    read_write_data_line_t           write_data_0_out;
    read_write_data_line_t           write_data_1_out;
    response_buffer_line_t [N-1:0]   req_response_out;
    logic [4:0]                      outstanding_out;
    logic                            idle_out;
    logic                            error_out;

    cu_data_write_engine_arbiter dut (
        .clock                       (clock),
        .rstn                        (rstn),
        .enabled_in                  (enabled_in),
        .req_valid_in                (req_valid_in),
        .req_command_in              (req_command_in),
        .req_data_0_in               (req_data_0_in),
        .req_data_1_in               (req_data_1_in),
        .req_grant_out               (req_grant_out),
        .write_command_buffer_status (write_command_buffer_status),
        .write_response_in           (write_response_in),
        .write_command_out           (write_command_out),
        .write_data_0_out            (write_data_0_out),
        .write_data_1_out            (write_data_1_out),
        .req_response_out            (req_response_out),
        .outstanding_out             (outstanding_out),
        .idle_out                    (idle_out),
        .error_out                   (error_out)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    int rsp_lane_exp = -1;

    typedef struct {
        logic [3:0] vld;
        logic       alf;
        int         rsp;
        logic [3:0] grant;
        int         outs;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        int w;
        @(posedge clock);
        #1;
        if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            check("cmd_valid",    64'(write_command_out.valid), 64'(1));
            check("cmd_cu_id",    64'(write_command_out.cmd.cu_id), 64'(BASE + cu_id_t'(w)));
            check("cmd_type",     64'(write_command_out.cmd.cmd_type), 64'(4'(w + 1)));
            check("cmd_address",  64'(write_command_out.address), 64'(32'hA000_0000 + 32'(w)));
            check("data0_valid",  64'(write_data_0_out.valid), 64'(1));
            check("data0_cu_id",  64'(write_data_0_out.cmd.cu_id), 64'(BASE + cu_id_t'(w)));
            check("data0_data",   write_data_0_out.data, 64'hD000_0000_0000_0000 + 64'(w));
            check("data1_valid",  64'(write_data_1_out.valid), 64'(1));
            check("data1_cu_id",  64'(write_data_1_out.cmd.cu_id), 64'(BASE + cu_id_t'(w)));
            check("data1_data",   write_data_1_out.data, 64'hE100_0000_0000_0000 + 64'(w));
        end else begin
            check("out_valid_idle",
                  64'({write_command_out.valid, write_data_0_out.valid, write_data_1_out.valid}), 64'(0));
        end
        for (int l = 0; l < N; l++) begin
            check("rsp_lane_valid", 64'(req_response_out[l].valid), 64'(l == rsp_lane_exp));
            if (l == rsp_lane_exp) begin
                check("rsp_lane_cu_id", 64'(req_response_out[l].cmd.cu_id), 64'(BASE + cu_id_t'(l)));
            end
        end
        rsp_lane_exp = -1;
    endtask

    task automatic cycle(input logic [3:0] vld, input logic alf, input int rsp, input logic [3:0] exp_g);
        req_valid_in = vld;
        write_command_buffer_status = '{alfull: alf, full: 1'b0, empty: 1'b0};
        write_response_in = '0;
        if (rsp >= 0) begin
            write_response_in.valid     = 1'b1;
            write_response_in.cmd.cu_id = BASE + cu_id_t'(rsp);
            write_response_in.cmd.tag   = 8'h5A;
        end
        #1;
        check("grant", 64'(req_grant_out), 64'(exp_g));
        for (int i = 0; i < N; i++) begin
            if (exp_g[i]) exp_q.push_back(i);
        end
        rsp_lane_exp = (rsp >= 0 && rsp < N) ? rsp : -1;
        tick();
        req_valid_in      = '0;
        write_response_in = '0;
    endtask

    initial begin
        logic [3:0] g;

        vecs[0]  = '{4'b1111, 1'b0, -1, 4'b0001, 1};
        vecs[1]  = '{4'b1111, 1'b0,  0, 4'b0010, 1};
        vecs[2]  = '{4'b1111, 1'b0,  1, 4'b0100, 1};
        vecs[3]  = '{4'b1111, 1'b0,  2, 4'b1000, 1};
        vecs[4]  = '{4'b1111, 1'b0,  3, 4'b0001, 1};
        vecs[5]  = '{4'b1111, 1'b0,  0, 4'b0010, 1};
        vecs[6]  = '{4'b1010, 1'b0,  1, 4'b1000, 1};
        vecs[7]  = '{4'b1010, 1'b0,  3, 4'b0010, 1};
        vecs[8]  = '{4'b1010, 1'b0,  1, 4'b1000, 1};
        vecs[9]  = '{4'b0000, 1'b0,  3, 4'b0000, 0};
        vecs[10] = '{4'b0100, 1'b0, -1, 4'b0100, 1};
        for (int i = 11; i <= 15; i++) vecs[i] = '{4'b1111, 1'b1, -1, 4'b0000, 1};
        vecs[16] = '{4'b1111, 1'b0, -1, 4'b1000, 2};

        rstn         = 1'b0;
        enabled_in   = 1'b0;
        req_valid_in = '0;
        write_command_buffer_status = '0;
        write_response_in = '0;
        for (int i = 0; i < N; i++) begin
            req_command_in[i]               = '0;
            req_command_in[i].cmd.cu_id     = 8'hEE;
            req_command_in[i].cmd.cmd_type  = 4'(i + 1);
            req_command_in[i].address       = 32'hA000_0000 + 32'(i);
            req_data_0_in[i]                = '0;
            req_data_0_in[i].cmd.cu_id      = 8'hEE;
            req_data_0_in[i].data           = 64'hD000_0000_0000_0000 + 64'(i);
            req_data_1_in[i]                = '0;
            req_data_1_in[i].cmd.cu_id      = 8'hEE;
            req_data_1_in[i].data           = 64'hE100_0000_0000_0000 + 64'(i);
        end

        #3;
        check("rst_grant",       64'(req_grant_out), 64'(0));
        check("rst_cmd_valid",   64'(write_command_out.valid), 64'(0));
        check("rst_outstanding", 64'(outstanding_out), 64'(0));
        check("rst_idle",        64'(idle_out), 64'(1));
        check("rst_error",       64'(error_out), 64'(0));

        @(posedge clock);
        #1;
        rstn       = 1'b1;
        enabled_in = 1'b1;
        cycle(4'b0000, 1'b0, -1, 4'b0000);
        cycle(4'b0000, 1'b0, -1, 4'b0000);
        check("active_not_idle", 64'(idle_out), 64'(0));

        for (int i = 0; i < 17; i++) begin
            cycle(vecs[i].vld, vecs[i].alf, vecs[i].rsp, vecs[i].grant);
            check("vec_outstanding", 64'(outstanding_out), 64'(vecs[i].outs));
        end

        cycle(4'b0000, 1'b0, 2, 4'b0000);
        cycle(4'b0000, 1'b0, 3, 4'b0000);
        check("empty_outstanding", 64'(outstanding_out), 64'(0));

        for (int k = 0; k < 20; k++) begin
            g = (k < 16) ? (4'b0001 << (k % 4)) : 4'b0000;
            cycle(4'b1111, 1'b0, -1, g);
        end
        check("credit_full", 64'(outstanding_out), 64'(16));
        cycle(4'b1111, 1'b0, 2, 4'b0000);
        check("credit_freed", 64'(outstanding_out), 64'(15));
        cycle(4'b1111, 1'b0, -1, 4'b0001);
        check("credit_refill", 64'(outstanding_out), 64'(16));
        cycle(4'b1111, 1'b0, -1, 4'b0000);

        for (int k = 0; k < 11; k++) cycle(4'b0000, 1'b0, 0, 4'b0000);
        check("down_to_5", 64'(outstanding_out), 64'(5));
        cycle(4'b0001, 1'b0, 0, 4'b0001);
        check("grant_and_rsp", 64'(outstanding_out), 64'(5));
        cycle(4'b0000, 1'b0, 1, 4'b0000);
        cycle(4'b0000, 1'b0, 1, 4'b0000);

        enabled_in = 1'b0;
        cycle(4'b0000, 1'b0, -1, 4'b0000);
        cycle(4'b0000, 1'b0, -1, 4'b0000);
        cycle(4'b1111, 1'b0, -1, 4'b0000);
        check("drain_outstanding", 64'(outstanding_out), 64'(3));
        check("drain_not_idle",    64'(idle_out), 64'(0));
        check("no_error_yet",      64'(error_out), 64'(0));
        cycle(4'b1111, 1'b0, 7, 4'b0000);
        check("bad_rsp_error",       64'(error_out), 64'(1));
        check("bad_rsp_outstanding", 64'(outstanding_out), 64'(3));
        cycle(4'b1111, 1'b0, 0, 4'b0000);
        cycle(4'b1111, 1'b0, 1, 4'b0000);
        cycle(4'b1111, 1'b0, 2, 4'b0000);
        check("drained_count", 64'(outstanding_out), 64'(0));
        check("drain_last",    64'(idle_out), 64'(0));
        cycle(4'b1111, 1'b0, -1, 4'b0000);
        check("drain_idle",    64'(idle_out), 64'(1));

        enabled_in = 1'b1;
        cycle(4'b0000, 1'b0, -1, 4'b0000);
        cycle(4'b0000, 1'b0, -1, 4'b0000);
        cycle(4'b1111, 1'b0, -1, 4'b0010);
        req_valid_in = 4'b1111;
        #1;
        check("pre_reset_grant", 64'(req_grant_out), 64'(4'b0100));
        #2;
        rstn = 1'b0;
        #1;
        exp_q.delete();
        check("async_grant",       64'(req_grant_out), 64'(0));
        check("async_cmd_valid",   64'(write_command_out.valid), 64'(0));
        check("async_outstanding", 64'(outstanding_out), 64'(0));
        check("async_idle",        64'(idle_out), 64'(1));
        check("async_error",       64'(error_out), 64'(0));
        req_valid_in = '0;
        @(posedge clock);
        #1;
        rstn = 1'b1;

        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
